// File: rtl/sound_play_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sound_play_ctrl
// Brief    : Audio playback sequencer. Walks a sample-ROM address through a
//            latched [start, end] window at one sample every DIV_N clocks,
//            captures each ROM word with a one-cycle valid strobe and drives
//            the PWM audio enable. Play / pause / stop are edge-triggered.
// Revision : 1.0 - initial release
// ============================================================================
module sound_play_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int DIV_W  = 11,
    parameter int DIV_N  = 1024
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              play_i,
    input  logic              pause_i,
    input  logic              stop_i,
    input  logic              loop_i,
    input  logic [ADDR_W-1:0] start_addr_i,
    input  logic [ADDR_W-1:0] end_addr_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [DATA_W-1:0] rom_data_i,
    output logic [DATA_W-1:0] sample_o,
    output logic              sample_vld_o,
    output logic              aud_en_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              cfg_err_o,
    output logic [1:0]        state_o
);

    // Divider value on the last clock of each sample period
    localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(DIV_N - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_start;
    logic [ADDR_W-1:0]   r_end;
    logic [DATA_W-1:0]   r_sample;
    logic [DIV_W-1:0]    r_div;
    logic                r_vld;
    logic                r_aud_en;
    logic                r_busy;
    logic                r_done;
    logic                r_cfg_err;

    logic                r_play_d;
    logic                r_pause_d;
    logic                r_stop_d;
    logic                r_play_edge;
    logic                r_pause_edge;
    logic                r_stop_edge;

    logic                w_tick;
    logic                w_at_end;

    assign w_tick   = (r_state == S_PLAY) && (r_div == C_DIV_LAST);
    assign w_at_end = (r_addr == r_end);

    // Rising-edge detection of the command levels; the delayed copies reset
    // high so a level held through reset release never looks like an edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_play_d     <= 1'b1;
            r_pause_d    <= 1'b1;
            r_stop_d     <= 1'b1;
            r_play_edge  <= 1'b0;
            r_pause_edge <= 1'b0;
            r_stop_edge  <= 1'b0;
        end else begin
            r_play_d     <= play_i;
            r_pause_d    <= pause_i;
            r_stop_d     <= stop_i;
            r_play_edge  <= play_i  & ~r_play_d;
            r_pause_edge <= pause_i & ~r_pause_d;
            r_stop_edge  <= stop_i  & ~r_stop_d;
        end
    end

    // Playback FSM with divider, address stepping and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_start   <= '0;
            r_end     <= '0;
            r_sample  <= '0;
            r_div     <= '0;
            r_vld     <= 1'b0;
            r_aud_en  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_vld     <= 1'b0;
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_play_edge) begin
                        if (start_addr_i <= end_addr_i) begin
                            r_start  <= start_addr_i;
                            r_end    <= end_addr_i;
                            r_addr   <= start_addr_i;
                            r_div    <= '0;
                            r_state  <= S_PLAY;
                            r_aud_en <= 1'b1;
                            r_busy   <= 1'b1;
                        end else begin
                            r_cfg_err <= 1'b1;
                        end
                    end
                end
                S_PLAY: begin
                    // A tick always completes, even if a command lands on it
                    if (w_tick) begin
                        r_sample <= rom_data_i;
                        r_vld    <= 1'b1;
                        r_div    <= '0;
                        if (!w_at_end) begin
                            r_addr <= r_addr + 1'b1;
                        end else if (loop_i) begin
                            r_addr <= r_start;
                        end
                    end else if (!r_pause_edge) begin
                        // Freeze on the pause cycle so resume keeps the phase
                        r_div <= r_div + 1'b1;
                    end

                    if (r_stop_edge) begin
                        r_state  <= S_IDLE;
                        r_aud_en <= 1'b0;
                        r_busy   <= 1'b0;
                    end else if (w_tick && w_at_end && !loop_i) begin
                        r_state  <= S_DONE;
                        r_aud_en <= 1'b0;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                    end else if (r_pause_edge) begin
                        r_state  <= S_PAUSE;
                        r_aud_en <= 1'b0;
                    end
                end
                S_PAUSE: begin
                    if (r_stop_edge) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_play_edge) begin
                        r_state  <= S_PLAY;
                        r_aud_en <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_aud_en <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign rom_addr_o   = r_addr;
    assign sample_o     = r_sample;
    assign sample_vld_o = r_vld;
    assign aud_en_o     = r_aud_en;
    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign cfg_err_o    = r_cfg_err;
    assign state_o      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_sound_play_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sound_play_ctrl
// Brief    : Self-checking bench for sound_play_ctrl with a sample scoreboard
// Revision : 1.0 - initial release
// ============================================================================
module tb_sound_play_ctrl;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int DIV_W  = 11;
    localparam int DIV_N  = 4;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              play_i = 1'b0;
    logic              pause_i = 1'b0;
    logic              stop_i = 1'b0;
    logic              loop_i = 1'b0;
    logic [ADDR_W-1:0] start_addr_i = '0;
    logic [ADDR_W-1:0] end_addr_i = '0;
    logic [ADDR_W-1:0] rom_addr_o;
    logic [DATA_W-1:0] rom_data_i;
    logic [DATA_W-1:0] sample_o;
    logic              sample_vld_o;
    logic              aud_en_o;
    logic              busy_o;
    logic              done_o;
    logic              cfg_err_o;
    logic [1:0]        state_o;

    int                n_checks = 0;
    int                n_pass = 0;
    int                cyc = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] sb_exp;

    sound_play_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DIV_W  (DIV_W),
        .DIV_N  (DIV_N)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .play_i       (play_i),
        .pause_i      (pause_i),
        .stop_i       (stop_i),
        .loop_i       (loop_i),
        .start_addr_i (start_addr_i),
        .end_addr_i   (end_addr_i),
        .rom_addr_o   (rom_addr_o),
        .rom_data_i   (rom_data_i),
        .sample_o     (sample_o),
        .sample_vld_o (sample_vld_o),
        .aud_en_o     (aud_en_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .cfg_err_o    (cfg_err_o),
        .state_o      (state_o)
    );

    // ROM contents: distinct, address-derived words
    function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
        return {~a, a} ^ 32'h1234_0000;
    endfunction

    assign rom_data_i = rom_word(rom_addr_o);

    // Clock generation
    always #5 clk = ~clk;

    // Cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every strobe must match the oldest expected sample
    always @(posedge clk) begin
        #1;
        if (sample_vld_o === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected: strobe with sample %h, none expected", sample_o);
            end else begin
                sb_exp = exp_q.pop_front();
                if (sample_o !== sb_exp)
                    $display("FAIL sb_sample: got %h, want %h", sample_o, sb_exp);
                else
                    n_pass++;
            end
        end
    end

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, got timeout, want finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_state(input logic [1:0] t, input int max, output bit ok);
        ok = (state_o == t);
        for (int i = 0; i < max && !ok; i++) begin
            step();
            ok = (state_o == t);
        end
    endtask

    task automatic wait_vld(input int max, output bit ok);
        ok = (sample_vld_o == 1'b1);
        for (int i = 0; i < max && !ok; i++) begin
            step();
            ok = (sample_vld_o == 1'b1);
        end
    endtask

    task automatic pulse_play();
        play_i = 1'b1;
        step();
        play_i = 1'b0;
    endtask

    task automatic pulse_stop();
        stop_i = 1'b1;
        step();
        stop_i = 1'b0;
    endtask

    task automatic test_reset();
        int n_busy;
        rstn = 1'b0;
        play_i = 1'b1;
        repeat (3) step();
        rstn = 1'b1;
        n_checks++;
        if (state_o !== 2'd0) $display("FAIL rst_state: got %0d, want 0", state_o);
        else n_pass++;
        n_checks++;
        if ({rom_addr_o, sample_o} !== '0) $display("FAIL rst_data: got addr %h sample %h, want 0", rom_addr_o, sample_o);
        else n_pass++;
        n_checks++;
        if ({sample_vld_o, aud_en_o, busy_o, done_o, cfg_err_o} !== 5'b0)
            $display("FAIL rst_flags: got %b, want 00000", {sample_vld_o, aud_en_o, busy_o, done_o, cfg_err_o});
        else n_pass++;
        n_busy = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (state_o != 2'd0 || busy_o) n_busy++;
        end
        n_checks++;
        if (n_busy != 0) $display("FAIL rst_play_held: got %0d active cycles, want 0", n_busy);
        else n_pass++;
        play_i = 1'b0;
        step();
    endtask

    task automatic test_single_pass();
        bit ok;
        int e, nstr, ndone;
        int off[3];
        start_addr_i = 16'd5; end_addr_i = 16'd7; loop_i = 1'b0;
        for (int a = 5; a <= 7; a++) exp_q.push_back(rom_word(ADDR_W'(a)));
        pulse_play();
        wait_state(2'd1, 6, ok);
        n_checks++;
        if (!ok || !aud_en_o || !busy_o) $display("FAIL single_enter: got ok=%0d aud=%0d busy=%0d, want 1 1 1", ok, aud_en_o, busy_o);
        else n_pass++;
        e = cyc; nstr = 0; ndone = 0;
        off = '{0, 0, 0};
        for (int i = 0; i < 16; i++) begin
            step();
            if (sample_vld_o) begin
                if (nstr < 3) off[nstr] = cyc - e;
                nstr++;
            end
            if (done_o) ndone++;
        end
        n_checks++;
        if (nstr != 3) $display("FAIL single_count: got %0d strobes, want 3", nstr);
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (off[k] != DIV_N * (k + 1)) $display("FAIL single_timing%0d: got %0d, want %0d", k, off[k], DIV_N * (k + 1));
            else n_pass++;
        end
        n_checks++;
        if (ndone != 1) $display("FAIL single_done: got %0d pulses, want 1", ndone);
        else n_pass++;
        n_checks++;
        if (state_o !== 2'd0 || aud_en_o !== 1'b0 || busy_o !== 1'b0)
            $display("FAIL single_end: got state %0d aud %0d busy %0d, want 0 0 0", state_o, aud_en_o, busy_o);
        else n_pass++;
        n_checks++;
        if (rom_addr_o !== 16'd7) $display("FAIL single_addr: got %h, want 0007", rom_addr_o);
        else n_pass++;
    endtask

    task automatic test_loop();
        bit ok;
        int nstr, ndone, nout;
        start_addr_i = 16'd5; end_addr_i = 16'd7; loop_i = 1'b1;
        for (int r = 0; r < 3; r++)
            for (int a = 5; a <= 7; a++) exp_q.push_back(rom_word(ADDR_W'(a)));
        pulse_play();
        wait_state(2'd1, 6, ok);
        nstr = 0; ndone = 0; nout = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (sample_vld_o) begin
                nstr++;
                if (nstr == 7) loop_i = 1'b0;
            end
            if (busy_o && (rom_addr_o < 16'd5 || rom_addr_o > 16'd7)) nout++;
            if (done_o) ndone++;
        end
        n_checks++;
        if (!ok || nstr != 9) $display("FAIL loop_count: got ok=%0d strobes=%0d, want 1 9", ok, nstr);
        else n_pass++;
        n_checks++;
        if (ndone != 1 || nout != 0) $display("FAIL loop_end: got done=%0d outside=%0d, want 1 0", ndone, nout);
        else n_pass++;
        n_checks++;
        if (state_o !== 2'd0) $display("FAIL loop_state: got %0d, want 0", state_o);
        else n_pass++;
    endtask

    task automatic test_pause();
        bit ok;
        int e, nbad;
        start_addr_i = 16'd5; end_addr_i = 16'd7; loop_i = 1'b1;
        exp_q.push_back(rom_word(16'd5));
        exp_q.push_back(rom_word(16'd6));
        pulse_play();
        wait_state(2'd1, 6, ok);
        wait_vld(10, ok);
        n_checks++;
        if (!ok) $display("FAIL pause_first: got no strobe, want strobe");
        else n_pass++;
        step();
        pause_i = 1'b1;
        step();
        pause_i = 1'b0;
        wait_state(2'd2, 5, ok);
        n_checks++;
        if (!ok || aud_en_o !== 1'b0 || busy_o !== 1'b1)
            $display("FAIL pause_enter: got ok=%0d aud=%0d busy=%0d, want 1 0 1", ok, aud_en_o, busy_o);
        else n_pass++;
        nbad = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (sample_vld_o || aud_en_o || state_o != 2'd2) nbad++;
        end
        n_checks++;
        if (nbad != 0) $display("FAIL pause_hold: got %0d bad cycles, want 0", nbad);
        else n_pass++;
        n_checks++;
        if (sample_o !== rom_word(16'd5) || rom_addr_o !== 16'd6)
            $display("FAIL pause_frozen: got sample %h addr %h, want %h 0006", sample_o, rom_addr_o, rom_word(16'd5));
        else n_pass++;
        pulse_play();
        wait_state(2'd1, 5, ok);
        e = cyc;
        wait_vld(10, ok);
        n_checks++;
        if (!ok || (cyc - e) != DIV_N - 2) $display("FAIL pause_resume: got ok=%0d delay=%0d, want 1 %0d", ok, cyc - e, DIV_N - 2);
        else n_pass++;
        pulse_stop();
        wait_state(2'd0, 5, ok);
        n_checks++;
        if (!ok || rom_addr_o !== 16'd7 || aud_en_o !== 1'b0 || busy_o !== 1'b0)
            $display("FAIL pause_stop: got ok=%0d addr=%h aud=%0d busy=%0d, want 1 0007 0 0", ok, rom_addr_o, aud_en_o, busy_o);
        else n_pass++;
        repeat (6) step();
    endtask

    task automatic test_cfg_err();
        int nerr, nbad;
        start_addr_i = 16'd9; end_addr_i = 16'd3; loop_i = 1'b0;
        pulse_play();
        nerr = 0; nbad = 0;
        for (int i = 0; i < 10; i++) begin
            if (cfg_err_o) nerr++;
            if (state_o != 2'd0 || sample_vld_o || busy_o) nbad++;
            step();
        end
        n_checks++;
        if (nerr != 1) $display("FAIL cfg_err_pulse: got %0d, want 1", nerr);
        else n_pass++;
        n_checks++;
        if (nbad != 0) $display("FAIL cfg_err_idle: got %0d active cycles, want 0", nbad);
        else n_pass++;
    endtask

    task automatic test_coincident();
        bit ok;
        int nbad;
        start_addr_i = 16'd5; end_addr_i = 16'd7; loop_i = 1'b1;
        pulse_play();
        wait_state(2'd1, 6, ok);
        play_i = 1'b1; pause_i = 1'b1; stop_i = 1'b1;
        step();
        play_i = 1'b0; pause_i = 1'b0; stop_i = 1'b0;
        wait_state(2'd0, 3, ok);
        n_checks++;
        if (!ok) $display("FAIL coinc_idle: got state %0d, want 0", state_o);
        else n_pass++;
        nbad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (state_o != 2'd0 || busy_o || sample_vld_o) nbad++;
        end
        n_checks++;
        if (nbad != 0) $display("FAIL coinc_stay: got %0d active cycles, want 0", nbad);
        else n_pass++;
    endtask

    task automatic test_top_window();
        bit ok;
        int nstr, nout;
        start_addr_i = 16'hFFFE; end_addr_i = 16'hFFFF; loop_i = 1'b1;
        for (int k = 0; k < 5; k++) exp_q.push_back(rom_word((k % 2 == 0) ? 16'hFFFE : 16'hFFFF));
        pulse_play();
        wait_state(2'd1, 6, ok);
        nstr = 0; nout = 0;
        for (int i = 0; i < 30 && nstr < 5; i++) begin
            step();
            if (sample_vld_o) nstr++;
            if (busy_o && rom_addr_o < 16'hFFFE) nout++;
        end
        pulse_stop();
        wait_state(2'd0, 5, ok);
        n_checks++;
        if (nstr != 5 || nout != 0) $display("FAIL top_window: got strobes=%0d wraps=%0d, want 5 0", nstr, nout);
        else n_pass++;
        n_checks++;
        if (!ok || rom_addr_o !== 16'hFFFF) $display("FAIL top_stop: got ok=%0d addr=%h, want 1 ffff", ok, rom_addr_o);
        else n_pass++;
        repeat (6) step();
    endtask

    task automatic test_async_reset();
        bit ok;
        int nbad;
        start_addr_i = 16'd5; end_addr_i = 16'd7; loop_i = 1'b1;
        exp_q.push_back(rom_word(16'd5));
        pulse_play();
        wait_state(2'd1, 6, ok);
        wait_vld(10, ok);
        step();
        rstn = 1'b0;
        #1;
        n_checks++;
        if (state_o !== 2'd0 || rom_addr_o !== '0 || sample_o !== '0)
            $display("FAIL arst_data: got state %0d addr %h sample %h, want 0 0 0", state_o, rom_addr_o, sample_o);
        else n_pass++;
        n_checks++;
        if ({sample_vld_o, aud_en_o, busy_o, done_o, cfg_err_o} !== 5'b0)
            $display("FAIL arst_flags: got %b, want 00000", {sample_vld_o, aud_en_o, busy_o, done_o, cfg_err_o});
        else n_pass++;
        play_i = 1'b1;
        step();
        step();
        rstn = 1'b1;
        nbad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (state_o != 2'd0 || busy_o) nbad++;
        end
        n_checks++;
        if (nbad != 0) $display("FAIL arst_no_restart: got %0d active cycles, want 0", nbad);
        else n_pass++;
        play_i = 1'b0;
        step();
        exp_q.push_back(rom_word(16'd5));
        pulse_play();
        wait_state(2'd1, 6, ok);
        wait_vld(10, ok);
        n_checks++;
        if (!ok) $display("FAIL arst_replay: got no strobe, want strobe");
        else n_pass++;
        pulse_stop();
        repeat (6) step();
    endtask

    // Test sequence
    initial begin
        test_reset();
        test_single_pass();
        test_loop();
        test_pause();
        test_cfg_err();
        test_coincident();
        test_top_window();
        test_async_reset();
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL sb_leftover: got %0d pending samples, want 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
